// File: rtl/lfsr_10bit_unit.sv
// lfsr_10bit_unit: maximal-length Fibonacci LFSR with registered wrap tick
//   clk          rising-edge clock
//   rst_en       asynchronous active-low reset, loads SEED and clears the tick
//   sh_en        advance one step per clock while high
//   Q_out        current LFSR state (WIDTH bits)
//   max_tick_reg one-cycle pulse on the edge whose shift lands back on SEED
module lfsr_10bit_unit #(
    parameter int               WIDTH = 17,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_en,
    input  logic             sh_en,
    output logic [WIDTH-1:0] Q_out,
    output logic             max_tick_reg
);
    // Tap bitmask per width: bit t-1 set for each tap t in the polynomial
    function automatic logic [23:0] tap_mask(input int w);
        case (w)
            3:       tap_mask = 24'h000006;
            4:       tap_mask = 24'h00000C;
            5:       tap_mask = 24'h000014;
            6:       tap_mask = 24'h000030;
            7:       tap_mask = 24'h000060;
            8:       tap_mask = 24'h0000B8;
            9:       tap_mask = 24'h000110;
            10:      tap_mask = 24'h000240;
            11:      tap_mask = 24'h000500;
            12:      tap_mask = 24'h000829;
            13:      tap_mask = 24'h00100D;
            14:      tap_mask = 24'h002015;
            15:      tap_mask = 24'h006000;
            16:      tap_mask = 24'h00D008;
            17:      tap_mask = 24'h012000;
            18:      tap_mask = 24'h020400;
            19:      tap_mask = 24'h040023;
            20:      tap_mask = 24'h090000;
            21:      tap_mask = 24'h140000;
            22:      tap_mask = 24'h300000;
            23:      tap_mask = 24'h420000;
            24:      tap_mask = 24'hE10000;
            default: tap_mask = 24'h000000;
        endcase
    endfunction

    localparam logic [WIDTH-1:0] TAPS     = WIDTH'(tap_mask(WIDTH));
    // An all-zero seed would lock the register, so it is replaced by 1
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;
    logic             r_tick;
    logic             w_zero;
    logic             w_fb;

    always_comb begin
        w_zero = (r_q == '0);
        w_fb   = ^(r_q & TAPS);
        // Zero state is a lock-up (e.g. upset); recover by reloading the seed
        w_next = w_zero ? SEED_EFF : {r_q[WIDTH-2:0], w_fb};
    end

    always_ff @(posedge clk or negedge rst_en) begin
        if (!rst_en) begin
            r_q    <= SEED_EFF;
            r_tick <= 1'b0;
        end else begin
            if (sh_en) r_q <= w_next;
            r_tick <= sh_en && !w_zero && (w_next == SEED_EFF);
        end
    end

    assign Q_out        = r_q;
    assign max_tick_reg = r_tick;
endmodule

// File: tb/tb_lfsr_10bit_unit.sv
// tb_lfsr_10bit_unit: directed vectors plus reference models for lfsr_10bit_unit
module tb_lfsr_10bit_unit;
    logic        clk = 1'b0;
    logic        rst_en = 1'b0;
    logic        sh_en = 1'b0;
    logic [16:0] q17;
    logic [9:0]  q10;
    logic [4:0]  q5;
    logic        tk17, tk10, tk5;

    logic [16:0] m17 = 17'h00001;
    logic [9:0]  m10 = 10'h001;
    logic [4:0]  m5  = 5'h01;
    logic        e17 = 1'b0, e10 = 1'b0, e5 = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        sh;
        logic [16:0] q;
        logic        tk;
    } vec_t;
    vec_t vecs[$];

    lfsr_10bit_unit u17 (.clk(clk), .rst_en(rst_en), .sh_en(sh_en), .Q_out(q17), .max_tick_reg(tk17));
    lfsr_10bit_unit #(.WIDTH(10), .SEED(10'h001)) u10 (.clk(clk), .rst_en(rst_en), .sh_en(sh_en), .Q_out(q10), .max_tick_reg(tk10));
    lfsr_10bit_unit #(.WIDTH(5), .SEED(5'h00)) u5 (.clk(clk), .rst_en(rst_en), .sh_en(sh_en), .Q_out(q5), .max_tick_reg(tk5));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic reset_models();
        m17 = 17'h00001; m10 = 10'h001; m5 = 5'h01;
        e17 = 1'b0; e10 = 1'b0; e5 = 1'b0;
    endtask

    task automatic check_models();
        chk("q17", 24'(q17), 24'(m17));
        chk("tick17", 24'(tk17), 24'(e17));
        chk("q10", 24'(q10), 24'(m10));
        chk("tick10", 24'(tk10), 24'(e10));
        chk("q5", 24'(q5), 24'(m5));
        chk("tick5", 24'(tk5), 24'(e5));
    endtask

    // One clock with the given enable; models advance by x^17+x^14+1, x^10+x^7+1, x^5+x^3+1
    task automatic step(input logic sh);
        sh_en = sh;
        @(posedge clk);
        if (!rst_en) reset_models();
        else if (sh) begin
            m17 = {m17[15:0], m17[16] ^ m17[13]};
            m10 = {m10[8:0], m10[9] ^ m10[6]};
            m5  = {m5[3:0], m5[4] ^ m5[2]};
            e17 = (m17 == 17'h00001);
            e10 = (m10 == 10'h001);
            e5  = (m5 == 5'h01);
        end else begin
            e17 = 1'b0; e10 = 1'b0; e5 = 1'b0;
        end
        #1;
        check_models();
    endtask

    logic seen[1024];
    int   ticks;

    initial begin
        for (int k = 1; k <= 13; k++) vecs.push_back('{1'b1, 17'(1) << k, 1'b0});
        vecs.push_back('{1'b1, 17'h04001, 1'b0});
        vecs.push_back('{1'b0, 17'h04001, 1'b0});
        vecs.push_back('{1'b1, 17'h08002, 1'b0});
        vecs.push_back('{1'b1, 17'h10004, 1'b0});
        vecs.push_back('{1'b0, 17'h10004, 1'b0});
        vecs.push_back('{1'b1, 17'h00009, 1'b0});
        vecs.push_back('{1'b1, 17'h00012, 1'b0});

        // Reset held with enable low, then with enable high
        for (int i = 0; i < 10; i++) begin
            sh_en = (i >= 5);
            @(posedge clk); #1;
            chk("rst_q17", 24'(q17), 24'h000001);
            chk("rst_tick17", 24'(tk17), 24'h0);
            chk("rst_q5_zero_seed", 24'(q5), 24'h000001);
        end
        rst_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            chk("hold_q17", 24'(q17), 24'h000001);
        end

        // Directed vectors from the seed
        foreach (vecs[i]) begin
            step(vecs[i].sh);
            chk($sformatf("vec%0d_q", i), 24'(q17), 24'(vecs[i].q));
            chk($sformatf("vec%0d_tick", i), 24'(tk17), 24'(vecs[i].tk));
        end

        // Full period of the 10-bit instance with a no-repeat scoreboard
        rst_en = 1'b0; #1;
        reset_models();
        @(negedge clk); rst_en = 1'b1;
        foreach (seen[k]) seen[k] = 1'b0;
        seen[1] = 1'b1;
        for (int i = 1; i <= 1023; i++) begin
            step(1'b1);
            chk("p10_nonzero", 24'(q10 == 10'h0), 24'h0);
            if (i < 1023) begin
                chk("p10_norepeat", 24'(seen[q10]), 24'h0);
                seen[q10] = 1'b1;
            end
        end
        chk("p10_wrap_q", 24'(q10), 24'h000001);
        chk("p10_wrap_tick", 24'(tk10), 24'h1);

        // Asynchronous reset between edges while the tick is high
        #2 rst_en = 1'b0;
        #1;
        chk("arst_q10", 24'(q10), 24'h000001);
        chk("arst_tick10", 24'(tk10), 24'h0);
        chk("arst_q17", 24'(q17), 24'h000001);
        chk("arst_tick17", 24'(tk17), 24'h0);
        reset_models();
        step(1'b1);
        chk("arst_sh_ignored", 24'(q17), 24'h000001);
        rst_en = 1'b1;
        step(1'b1);
        chk("arst_restart", 24'(q17), 24'h000002);

        // Enable toggling across the 10-bit wrap
        rst_en = 1'b0; #1;
        reset_models();
        @(negedge clk); rst_en = 1'b1;
        ticks = 0;
        for (int i = 0; i < 2100; i++) begin
            step(i % 2 == 0);
            if (tk10) ticks++;
            if (i % 2 == 1) chk("tog_tick_on_disabled", 24'(tk10), 24'h0);
        end
        chk("tog_tick_count", 24'(ticks), 24'h000001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
